// File: rtl/slap_pkg.sv
// ============================================================================
// Module   : slap_pkg
// Brief    : Shared types and work-RAM decode constants for the Slap Fight core
// Revision : 1.0
// ============================================================================
`default_nettype none

package slap_pkg;

  localparam int          WRAM_AW   = 11;
  localparam logic [15:0] WRAM_BASE = 16'hC800;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    SETTLE  = 3'd2,
    GRANT   = 3'd3,
    RD_WAIT = 3'd4,
    RELEASE = 3'd5
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/slap_idle_counter.sv
// ============================================================================
// Module   : slap_idle_counter
// Brief    : Saturating up-counter with clear/enable; o_tc once count >= TERM
// Revision : 1.0
// ============================================================================
`default_nettype none

module slap_idle_counter #(
  parameter int W    = 4,
  parameter int TERM = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [W-1:0] C_TERM = W'(TERM);

  logic [W-1:0] r_count;

  assign o_tc = (r_count >= C_TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/slap_wram_arbiter.sv
// ============================================================================
// Module   : slap_wram_arbiter
// Brief    : Shares the main-CPU work RAM between the Z80 and the hiscore engine
// Revision : 1.0
// ============================================================================
`default_nettype none

module slap_wram_arbiter
  import slap_pkg::*;
#(
  parameter int          ADDR_W       = WRAM_AW,
  parameter logic [15:0] WIN_BASE     = WRAM_BASE,
  parameter int          SETTLE_CYC   = 4,
  parameter int          HOLD_TIMEOUT = 1023
) (
  input  logic              clkm_36MHZ,
  input  logic              RESET_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_we,
  input  logic              cpu_mreq_n,
  output logic [7:0]        cpu_din,
  output logic              cpu_hold,
  input  logic              hs_req,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  output logic [7:0]        hs_data_out,
  output logic              hs_grant,
  output logic              hs_valid,
  output logic              hs_error,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int C_TO_W = $clog2(HOLD_TIMEOUT + 1);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic [15:0] w_offset;
  logic        w_in_win;
  logic        w_hs_side;
  logic        w_settle_clr;
  logic        w_settle_tc;
  logic        w_to_tc;
  logic        w_timeout_fire;
  logic        r_forced;
  logic        r_rd_in_win;
  logic        r_hs_error;
  logic        r_hs_valid;
  logic [7:0]  r_hs_data_out;
  logic [7:0]  r_cpu_din;
  logic        r_cpu_hold;
  logic        r_hs_grant;

  // Window test uses 16-bit wrap-around, so addresses below the base are out.
  assign w_offset       = hs_address - WIN_BASE;
  assign w_in_win       = ((w_offset >> ADDR_W) == 16'd0);
  assign w_hs_side      = (r_state == GRANT) || (r_state == RD_WAIT);
  assign w_timeout_fire = (r_state == HOLD) && hs_req && !cpu_mreq_n && w_to_tc;
  // After a forced grant the bus never goes quiet, so settling just counts time.
  assign w_settle_clr   = (r_state != SETTLE) || (!cpu_mreq_n && !r_forced);

  slap_idle_counter #(
    .W    (4),
    .TERM (SETTLE_CYC - 1)
  ) u_settle_cnt (
    .clk   (clkm_36MHZ),
    .rst_n (RESET_n),
    .i_clr (w_settle_clr),
    .i_en  (r_state == SETTLE),
    .o_tc  (w_settle_tc)
  );

  slap_idle_counter #(
    .W    (C_TO_W),
    .TERM (HOLD_TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clkm_36MHZ),
    .rst_n (RESET_n),
    .i_clr (r_state != HOLD),
    .i_en  (r_state == HOLD),
    .o_tc  (w_to_tc)
  );

  always_ff @(posedge clkm_36MHZ) begin
    if (!RESET_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (hs_req) w_next_state = HOLD;
      HOLD: begin
        if (!hs_req)                   w_next_state = RELEASE;
        else if (cpu_mreq_n || w_to_tc) w_next_state = SETTLE;
      end
      SETTLE: begin
        if (!hs_req)                                  w_next_state = RELEASE;
        else if (w_settle_tc && (cpu_mreq_n || r_forced)) w_next_state = GRANT;
      end
      GRANT: begin
        if (!hs_req)        w_next_state = RELEASE;
        else if (!hs_write) w_next_state = RD_WAIT;
      end
      RD_WAIT: w_next_state = GRANT;
      RELEASE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = cpu_we;
    ram_wdata = cpu_dout;
    if (w_hs_side) begin
      ram_addr  = w_offset[ADDR_W-1:0];
      ram_wdata = hs_data_in;
      ram_we    = (r_state == GRANT) && hs_req && hs_write && w_in_win;
    end
    if (!RESET_n) begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clkm_36MHZ) begin
    if (!RESET_n) begin
      r_forced      <= 1'b0;
      r_rd_in_win   <= 1'b0;
      r_hs_error    <= 1'b0;
      r_hs_valid    <= 1'b0;
      r_hs_data_out <= '0;
      r_cpu_din     <= '0;
      r_cpu_hold    <= 1'b0;
      r_hs_grant    <= 1'b0;
    end else begin
      r_cpu_din  <= ram_rdata;
      r_cpu_hold <= (w_next_state != IDLE);
      r_hs_grant <= (w_next_state == GRANT) || (w_next_state == RD_WAIT);
      r_hs_valid <= (r_state == RD_WAIT);
      if (r_state == IDLE)   r_forced    <= 1'b0;
      else if (w_timeout_fire) r_forced  <= 1'b1;
      if (r_state == GRANT)  r_rd_in_win <= w_in_win;
      if (r_state == RD_WAIT) begin
        r_hs_data_out <= r_rd_in_win ? ram_rdata : 8'hFF;
      end
      if (r_state != IDLE && w_next_state == IDLE) begin
        r_hs_error <= 1'b0;
      end else if (w_timeout_fire || (r_state == GRANT && hs_req && !w_in_win)) begin
        r_hs_error <= 1'b1;
      end
    end
  end

  assign cpu_din     = r_cpu_din;
  assign cpu_hold    = r_cpu_hold;
  assign hs_grant    = r_hs_grant;
  assign hs_valid    = r_hs_valid;
  assign hs_error    = r_hs_error;
  assign hs_data_out = r_hs_data_out;

endmodule

`default_nettype wire
